// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg: shared encodings for the register-file instruction sequencer.
// Covers opcode values, instruction field positions, FSM state encoding and select widths.
package regfile_ctrl_pkg;

  localparam int SEL_W   = 3;
  localparam int OP_W    = 4;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 4;

  // Instruction field bit positions
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 9;
  localparam int RA_MSB = 8;
  localparam int RA_LSB = 6;
  localparam int RB_MSB = 5;
  localparam int RB_LSB = 3;

  // Opcode encodings; 8..15 are illegal
  localparam logic [OP_W-1:0] OP_NOP = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB = 4'd2;
  localparam logic [OP_W-1:0] OP_AND = 4'd3;
  localparam logic [OP_W-1:0] OP_OR  = 4'd4;
  localparam logic [OP_W-1:0] OP_MOV = 4'd5;
  localparam logic [OP_W-1:0] OP_LDI = 4'd6;
  localparam logic [OP_W-1:0] OP_MUL = 4'd7;

  // Register select 0: no write on DSEL, DIN on ASEL
  localparam logic [SEL_W-1:0] DSEL_NONE = 3'd0;
  localparam logic [SEL_W-1:0] SEL_DIN   = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Legal ops other than NOP write their destination register
  function automatic logic op_writes(input logic [OP_W-1:0] op);
    return (op != OP_NOP) && !op[OP_W-1];
  endfunction

  // OP values 8..15 are illegal
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op[OP_W-1];
  endfunction

endpackage

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: sequences one register-to-register instruction at a time through
// IDLE -> EXEC -> WB, driving register-file selects and the ALU opcode.
// Handshake: an instruction transfers on a rising CLK edge where INSTR_VALID and
// INSTR_READY are both high; INSTR_READY is high only in IDLE, and INSTR/INSTR_VALID
// are ignored in every other state.
// Optional feature: define REGFILE_CTRL_RETIRE_CNT_EN to add the 16-bit RETIRE_CNT output.
// DBG_STATE exposes the FSM state (0 IDLE, 1 EXEC, 2 WB) for checkers.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INSTR_VALID,
  input  logic [15:0] INSTR,
  output logic        INSTR_READY,
  output logic [2:0]  ASEL,
  output logic [2:0]  BSEL,
  output logic [2:0]  DSEL,
  output logic [3:0]  ALU_OP,
  output logic        BUSY,
  output logic        DONE,
  output logic        ILLEGAL,
  output logic [1:0]  DBG_STATE
`ifdef REGFILE_CTRL_RETIRE_CNT_EN
  ,
  output logic [15:0] RETIRE_CNT
`endif
);

  localparam logic [CNT_W-1:0] MUL_CYC = CNT_W'(MUL_LAT);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SEL_W-1:0] rd_q;
  logic [SEL_W-1:0] asel_q;
  logic [SEL_W-1:0] bsel_q;
  logic [SEL_W-1:0] dsel_q;
  logic [OP_W-1:0]  alu_op_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             illegal_q;

  // Decoded fields of the incoming instruction
  logic [OP_W-1:0]  in_op;
  logic [SEL_W-1:0] in_rd;
  logic [SEL_W-1:0] in_ra;
  logic [SEL_W-1:0] in_rb;
  logic [2:0]       unused_bits;

  assign in_op       = INSTR[OP_MSB:OP_LSB];
  assign in_rd       = INSTR[RD_MSB:RD_LSB];
  assign in_ra       = INSTR[RA_MSB:RA_LSB];
  assign in_rb       = INSTR[RB_MSB:RB_LSB];
  assign unused_bits = INSTR[2:0];

  // Sequencer FSM with registered outputs; reset drops any pending write at once
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_q      <= '0;
      asel_q    <= '0;
      bsel_q    <= '0;
      dsel_q    <= DSEL_NONE;
      alu_op_q  <= OP_NOP;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (INSTR_VALID) begin
            state_q  <= ST_EXEC;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            rd_q     <= in_rd;
            alu_op_q <= in_op;
            asel_q   <= (in_op == OP_LDI) ? SEL_DIN : in_ra;
            bsel_q   <= (in_op == OP_MOV) ? 3'd0 : in_rb;
            dsel_q   <= DSEL_NONE;
            // Counter holds the number of EXEC cycles still to spend
            cnt_q    <= (in_op == OP_MUL) ? MUL_CYC : CNT_W'(1);
          end
        end
        ST_EXEC: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_q   <= ST_WB;
            cnt_q     <= '0;
            dsel_q    <= op_writes(alu_op_q) ? rd_q : DSEL_NONE;
            done_q    <= 1'b1;
            illegal_q <= op_illegal(alu_op_q);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_WB: begin
          state_q   <= ST_IDLE;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
          dsel_q    <= DSEL_NONE;
          asel_q    <= '0;
          bsel_q    <= '0;
          alu_op_q  <= OP_NOP;
        end
        default: begin
          state_q   <= ST_IDLE;
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
          dsel_q    <= DSEL_NONE;
          asel_q    <= '0;
          bsel_q    <= '0;
          alu_op_q  <= OP_NOP;
          cnt_q     <= '0;
        end
      endcase
    end
  end

`ifdef REGFILE_CTRL_RETIRE_CNT_EN
  logic [15:0] retire_cnt_q;

  // Count every retired instruction (each WB cycle), wrapping at 16 bits
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      retire_cnt_q <= '0;
    end else if (state_q == ST_WB) begin
      retire_cnt_q <= retire_cnt_q + 16'd1;
    end
  end

  assign RETIRE_CNT = retire_cnt_q;
`endif

  assign INSTR_READY = ready_q;
  assign ASEL        = asel_q;
  assign BSEL        = bsel_q;
  assign DSEL        = dsel_q;
  assign ALU_OP      = alu_op_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign ILLEGAL     = illegal_q;
  assign DBG_STATE   = state_q;

endmodule
